// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EXE-side tag pipeline, operand forwarding muxes,
// load-use stall and taken-branch flush control with event counters.
module hazard_fwd_unit #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 4,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [REG_AW-1:0]           id_rp,
  input  logic [REG_AW-1:0]           id_rs,
  input  logic                        id_use_rp,
  input  logic                        id_use_rs,
  input  logic [REG_AW-1:0]           id_rg,
  input  logic                        id_wr,
  input  logic                        id_load,
  input  logic                        ex_branch_taken,
  input  logic [FWD_DEPTH*DATA_W-1:0] stage_result,
  output logic                        stall,
  output logic                        flush,
  output logic [2:0]                  fwd_a_sel,
  output logic [2:0]                  fwd_b_sel,
  output logic [DATA_W-1:0]           fwd_a_data,
  output logic [DATA_W-1:0]           fwd_b_data,
  output logic [15:0]                 stall_cnt,
  output logic [15:0]                 flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rg;
    logic              wr;
    logic              load;
  } tag_t;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } state_t;

  tag_t              tags_q [FWD_DEPTH+1];
  tag_t              issue_tag;
  logic              issue;
  logic              hazard;
  logic [REG_AW-1:0] ex_rp;
  logic [REG_AW-1:0] ex_rs;
  logic              ex_use_rp;
  logic              ex_use_rs;
  state_t            state_q;
  state_t            state_d;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              flush_q;

  assign issue     = id_valid && !stall && !flush;
  assign issue_tag = '{valid: 1'b1, rg: id_rg, wr: id_wr, load: id_load};

  assign hazard = tags_q[0].valid && tags_q[0].load &&
                  tags_q[0].wr && id_valid &&
                  ((id_use_rp && id_rp == tags_q[0].rg) ||
                   (id_use_rs && id_rs == tags_q[0].rg));

  // Walk from the oldest stage down so the youngest match is kept.
  always_comb begin
    fwd_a_sel  = '0;
    fwd_b_sel  = '0;
    fwd_a_data = '0;
    fwd_b_data = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (tags_q[k].valid && tags_q[k].wr &&
          (!tags_q[k].load || k > LOAD_LAT)) begin
        if (ex_use_rp && tags_q[k].rg == ex_rp) begin
          fwd_a_sel  = 3'(k);
          fwd_a_data = stage_result[(k-1)*DATA_W +: DATA_W];
        end
        if (ex_use_rs && tags_q[k].rg == ex_rs) begin
          fwd_b_sel  = 3'(k);
          fwd_b_data = stage_result[(k-1)*DATA_W +: DATA_W];
        end
      end
    end
  end

  // The hazard cycle is the first stall; STALL releases ID once cnt is 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hazard) begin
          stall   = 1'b1;
          state_d = STALL;
          cnt_d   = 2'(LOAD_LAT - 1);
        end
      end
      STALL: begin
        stall = (cnt_q != 2'd0);
        if (cnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (ex_branch_taken) begin
      flush   = 1'b1;
      stall   = 1'b0;
      state_d = FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        tags_q[k] <= '0;
      end
      ex_rp     <= '0;
      ex_rs     <= '0;
      ex_use_rp <= 1'b0;
      ex_use_rs <= 1'b0;
      state_q   <= RUN;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      tags_q[0] <= issue ? issue_tag : '0;
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        tags_q[k] <= tags_q[k-1];
      end
      if (issue) begin
        ex_rp <= id_rp;
        ex_rs <= id_rs;
      end
      ex_use_rp <= issue && id_use_rp;
      ex_use_rs <= issue && id_use_rs;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush;
      if (stall && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (flush && !flush_q && flush_cnt != 16'hFFFF) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding scoreboard, load-use,
// branch flush, reset abort, plus counter saturation on a deep instance.
module tb_hazard_fwd_unit;

  localparam int DW      = 32;
  localparam int AW      = 4;
  localparam int SAT_CYC = 87392;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          id_valid;
  logic [AW-1:0] id_rp;
  logic [AW-1:0] id_rs;
  logic          id_use_rp;
  logic          id_use_rs;
  logic [AW-1:0] id_rg;
  logic          id_wr;
  logic          id_load;
  logic          br;
  logic [2*DW-1:0] res;
  logic          stall;
  logic          flush;
  logic [2:0]    sa;
  logic [2:0]    sb;
  logic [DW-1:0] da;
  logic [DW-1:0] db;
  logic [15:0]   scnt;
  logic [15:0]   fcnt;

  logic            rst_s_n;
  logic [4*DW-1:0] res_s;
  logic            s_stall;
  logic            s_flush;
  logic [2:0]      s_sa;
  logic [2:0]      s_sb;
  logic [DW-1:0]   s_da;
  logic [DW-1:0]   s_db;
  logic [15:0]     s_scnt;
  logic [15:0]     s_fcnt;

  int total = 0;
  int bad   = 0;

  hazard_fwd_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rp(id_rp), .id_rs(id_rs),
    .id_use_rp(id_use_rp), .id_use_rs(id_use_rs),
    .id_rg(id_rg), .id_wr(id_wr), .id_load(id_load),
    .ex_branch_taken(br), .stage_result(res),
    .stall(stall), .flush(flush),
    .fwd_a_sel(sa), .fwd_b_sel(sb),
    .fwd_a_data(da), .fwd_b_data(db),
    .stall_cnt(scnt), .flush_cnt(fcnt)
  );

  // Self-dependent load held in ID: stalls 3 of every 4 cycles.
  hazard_fwd_unit #(.FWD_DEPTH(4), .LOAD_LAT(3)) dut_s (
    .clk(clk), .rst_n(rst_s_n), .id_valid(1'b1),
    .id_rp(4'd5), .id_rs(4'd0),
    .id_use_rp(1'b1), .id_use_rs(1'b0),
    .id_rg(4'd5), .id_wr(1'b1), .id_load(1'b1),
    .ex_branch_taken(1'b0), .stage_result(res_s),
    .stall(s_stall), .flush(s_flush),
    .fwd_a_sel(s_sa), .fwd_b_sel(s_sb),
    .fwd_a_data(s_da), .fwd_b_data(s_db),
    .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
  );

  typedef struct {
    string       tag;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [31:0] da;
    logic [31:0] db;
  } exp_t;

  exp_t sb_q[$];

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [AW-1:0] rg, input logic wr,
                    input logic ld, input logic [AW-1:0] rp,
                    input logic urp, input logic [AW-1:0] rs,
                    input logic urs);
    id_valid  = 1'b1;
    id_rg     = rg;
    id_wr     = wr;
    id_load   = ld;
    id_rp     = rp;
    id_use_rp = urp;
    id_rs     = rs;
    id_use_rs = urs;
  endtask

  task automatic idle();
    id_valid  = 1'b0;
    id_rg     = '0;
    id_wr     = 1'b0;
    id_load   = 1'b0;
    id_rp     = '0;
    id_use_rp = 1'b0;
    id_rs     = '0;
    id_use_rs = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      adv();
      idle();
    end
  endtask

  task automatic push(input string tag, input logic [2:0] a,
                      input logic [2:0] b, input logic [31:0] x,
                      input logic [31:0] y);
    exp_t e;
    e.tag = tag;
    e.sa  = a;
    e.sb  = b;
    e.da  = x;
    e.db  = y;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_underflow: got empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_sa"}, 32'(sa), 32'(e.sa));
      chk({e.tag, "_sb"}, 32'(sb), 32'(e.sb));
      chk({e.tag, "_da"}, da, e.da);
      chk({e.tag, "_db"}, db, e.db);
    end
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] smodel;
    logic        mid_done;
    rst_n   = 1'b0;
    rst_s_n = 1'b0;
    br      = 1'b0;
    res     = {32'h2A, 32'h15};
    res_s   = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
    idle();
    repeat (2) adv();
    settle();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_sa", 32'(sa), 32'd0);
    chk("rst_sb", 32'(sb), 32'd0);
    chk("rst_scnt", 32'(scnt), 32'd0);
    chk("rst_fcnt", 32'(fcnt), 32'd0);
    adv();
    rst_n = 1'b1;

    // ADD r3 ; SUB r4 = r3 - r1
    adv(); op(4'd3, 1, 0, 4'd1, 1, 4'd2, 1);
    adv(); op(4'd4, 1, 0, 4'd3, 1, 4'd1, 1);
    push("fwd_s1", 3'd1, 3'd0, 32'h15, 32'h0);
    adv(); idle(); settle(); pop_chk();
    gap(2);

    // two producers of r3, youngest wins on both operands
    adv(); op(4'd3, 1, 0, 4'd1, 1, 4'd2, 1);
    adv(); op(4'd3, 1, 0, 4'd1, 1, 4'd2, 1);
    adv(); op(4'd7, 1, 0, 4'd3, 1, 4'd3, 1);
    push("youngest", 3'd1, 3'd1, 32'h15, 32'h15);
    adv(); idle(); settle(); pop_chk();
    gap(2);

    // ALU result forwarded from stage 2
    adv(); op(4'd8, 1, 0, 4'd1, 1, 4'd2, 1);
    adv(); idle();
    adv(); op(4'd9, 1, 0, 4'd8, 1, 4'd2, 0);
    push("fwd_s2", 3'd2, 3'd0, 32'h2A, 32'h0);
    adv(); idle(); settle(); pop_chk();
    gap(2);

    // rp matches but is unused; rs matches and is used
    adv(); op(4'd9, 1, 0, 4'd1, 1, 4'd2, 1);
    adv(); op(4'd10, 1, 0, 4'd9, 0, 4'd9, 1);
    push("b_only", 3'd0, 3'd1, 32'h0, 32'h15);
    adv(); idle(); settle(); pop_chk();
    gap(2);

    // r0 forwards like any other register
    adv(); op(4'd0, 1, 0, 4'd1, 1, 4'd2, 1);
    adv(); op(4'd11, 1, 0, 4'd0, 1, 4'd2, 1);
    push("r0", 3'd1, 3'd0, 32'h15, 32'h0);
    adv(); idle(); settle(); pop_chk();
    gap(2);

    // producer without write enable
    adv(); op(4'd3, 0, 0, 4'd1, 1, 4'd2, 1);
    adv(); op(4'd4, 1, 0, 4'd3, 1, 4'd3, 1);
    push("no_wr", 3'd0, 3'd0, 32'h0, 32'h0);
    adv(); idle(); settle(); pop_chk();
    gap(2);

    // LOAD r5 ; ADD r6 = r5 + r5
    adv(); op(4'd5, 1, 1, 4'd1, 1, 4'd2, 0);
    adv(); op(4'd6, 1, 0, 4'd5, 1, 4'd5, 1); settle();
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_flush", 32'(flush), 32'd0);
    chk("lu_scnt0", 32'(scnt), 32'd0);
    adv(); settle();
    chk("lu_release", 32'(stall), 32'd0);
    chk("lu_bubble", 32'(sa), 32'd0);
    chk("lu_scnt1", 32'(scnt), 32'd1);
    push("load_use", 3'd2, 3'd2, 32'h2A, 32'h2A);
    adv(); idle(); settle(); pop_chk();
    chk("lu_stall_after", 32'(stall), 32'd0);
    chk("lu_scnt_hold", 32'(scnt), 32'd1);
    gap(2);

    // load-use hazard coinciding with a taken branch
    adv(); op(4'd5, 1, 1, 4'd1, 1, 4'd2, 0);
    adv(); op(4'd6, 1, 0, 4'd5, 1, 4'd5, 1); br = 1'b1; settle();
    chk("br_stall", 32'(stall), 32'd0);
    chk("br_flush", 32'(flush), 32'd1);
    adv(); br = 1'b0; settle();
    chk("fl_flush", 32'(flush), 32'd1);
    chk("fl_stall", 32'(stall), 32'd0);
    chk("fl_fcnt", 32'(fcnt), 32'd1);
    push("squash", 3'd0, 3'd0, 32'h0, 32'h0);
    adv(); idle(); settle(); pop_chk();
    chk("fl_done", 32'(flush), 32'd0);
    chk("fl_fcnt_hold", 32'(fcnt), 32'd1);
    chk("fl_scnt_hold", 32'(scnt), 32'd1);
    gap(2);

    // reset asserted during the stall cycle
    adv(); op(4'd5, 1, 1, 4'd1, 1, 4'd2, 0);
    adv(); op(4'd6, 1, 0, 4'd5, 1, 4'd5, 1); settle();
    chk("rs_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    adv(); rst_n = 1'b1; settle();
    chk("rs_stall_clr", 32'(stall), 32'd0);
    chk("rs_flush", 32'(flush), 32'd0);
    chk("rs_sa", 32'(sa), 32'd0);
    chk("rs_sb", 32'(sb), 32'd0);
    chk("rs_scnt", 32'(scnt), 32'd0);
    chk("rs_fcnt", 32'(fcnt), 32'd0);
    push("after_rst", 3'd0, 3'd0, 32'h0, 32'h0);
    adv(); idle(); settle(); pop_chk();
    chk("rs_no_pending", 32'(stall), 32'd0);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    // deep instance: 3-cycle load-use stalls up to counter saturation
    adv();
    rst_s_n  = 1'b1;
    smodel   = '0;
    mid_done = 1'b0;
    for (int n = 1; n <= SAT_CYC; n++) begin
      adv();
      if ((n - 1) % 4 != 0 && smodel != 16'hFFFF) smodel++;
      if (n == 5) begin
        settle();
        chk("s_stall_c5", 32'(s_stall), 32'd1);
        chk("s_fwd4_sel", 32'(s_sa), 32'd4);
        chk("s_fwd4_data", s_da, 32'hD4);
      end
      if (n == 8) chk("s_scnt_c8", 32'(s_scnt), 32'd6);
      if (smodel == 16'd65530 && !mid_done) begin
        mid_done = 1'b1;
        chk("s_scnt_mid", 32'(s_scnt), 32'(smodel));
      end
    end
    chk("s_scnt_sat", 32'(s_scnt), 32'hFFFF);
    chk("s_scnt_model", 32'(s_scnt), 32'(smodel));
    chk("s_fcnt", 32'(s_fcnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
